// File: rtl/instr_mem_loader.sv
// Byte-streamed program loader feeding a byte-addressed instruction memory.
// Fetches return four bytes big-endian starting at addr, with out-of-range lanes reading zero.
module instr_mem_loader #(
   parameter int unsigned MEM_SIZE = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        byte_last,
   output logic        byte_ready,
   output logic        load_busy,
   output logic        load_done,
   output logic        overflow,
   output logic [31:0] byte_count,
   input  logic [63:0] addr,
   output logic [31:0] instr,
   output logic        instr_valid
);

   localparam int unsigned AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

   typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] clr_ptr_q, clr_ptr_d;
   logic [31:0]   byte_count_q, byte_count_d;
   logic          overflow_q, overflow_d;

   logic          we;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata;
   logic          in_range;

   logic [7:0]    mem [MEM_SIZE];

   always_comb begin
      state_d      = state_q;
      clr_ptr_d    = clr_ptr_q;
      byte_count_d = byte_count_q;
      overflow_d   = overflow_q;
      we           = 1'b0;
      waddr        = clr_ptr_q;
      wdata        = 8'h00;
      in_range     = {32'd0, byte_count_q} < 64'(MEM_SIZE);
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = CLEAR;
               clr_ptr_d    = '0;
               byte_count_d = '0;
               overflow_d   = 1'b0;
            end
         end
         CLEAR: begin
            we        = 1'b1;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(MEM_SIZE - 1)) state_d = LOAD;
         end
         LOAD: begin
            if (byte_valid) begin
               if (in_range) begin
                  we    = 1'b1;
                  waddr = byte_count_q[AW-1:0];
                  wdata = byte_data;
               end else begin
                  overflow_d = 1'b1;
               end
               if (byte_count_q != '1) byte_count_d = byte_count_q + 32'd1;
               if (byte_last) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         clr_ptr_q    <= '0;
         byte_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_ptr_q    <= clr_ptr_d;
         byte_count_q <= byte_count_d;
         overflow_q   <= overflow_d;
      end
   end

   // Memory has no reset; a reset edge only suppresses the write in flight.
   always_ff @(posedge clk) begin
      if (we && !reset) mem[waddr] <= wdata;
   end

   // Each lane wraps independently at 2^64 and reads zero when out of range.
   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [63:0] lane_addr;
      assign lane_addr = addr + 64'(k);
      assign instr[31-8*k -: 8] = (lane_addr < 64'(MEM_SIZE)) ? mem[lane_addr[AW-1:0]] : 8'h00;
   end

   assign byte_ready  = (state_q == LOAD);
   assign load_busy   = (state_q == CLEAR) || (state_q == LOAD);
   assign load_done   = (state_q == DONE);
   assign instr_valid = (state_q == DONE);
   assign overflow    = overflow_q;
   assign byte_count  = byte_count_q;

endmodule
